// File: rtl/common.sv
// Shared divider types: XLEN word, FSM state encoding and iteration counts.
// Pure declarations; no timing or flow control.
package common;
    localparam int XLEN = 64;
    localparam int W_LEN = 32;

    typedef logic [XLEN-1:0] u64;

    typedef enum logic [1:0] {
        DIV_IDLE,
        DIV_BUSY,
        DIV_DONE
    } div_state_t;

    localparam int DIV_ITER_D = 64;
    localparam int DIV_ITER_W = 32;
endpackage

// File: rtl/div_operand_fix.sv
// Combinational operand prep (W extension, magnitudes, div-by-zero/overflow) and
// result fix-up (sign correction, W sign-extension); zero latency, no flow control.
module div_operand_fix
    import common::*;
#(
    parameter int XLEN  = 64,
    parameter int W_LEN = 32
) (
    input  logic [XLEN-1:0] src_a,
    input  logic [XLEN-1:0] src_b,
    input  logic            sign,
    input  logic            w,
    output logic [XLEN-1:0] mag_a,
    output logic [XLEN-1:0] mag_b,
    output logic            neg_q,
    output logic            neg_r,
    output logic            special,
    output logic [XLEN-1:0] spec_q,
    output logic [XLEN-1:0] spec_r,
    input  logic [XLEN-1:0] raw_q,
    input  logic [XLEN-1:0] raw_r,
    input  logic            fix_neg_q,
    input  logic            fix_neg_r,
    input  logic            fix_w,
    output logic [XLEN-1:0] res_q,
    output logic [XLEN-1:0] res_r
);
    localparam logic [XLEN-1:0] MIN_D = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] MIN_W = {{(XLEN-W_LEN+1){1'b1}}, {(W_LEN-1){1'b0}}};

    function automatic logic [XLEN-1:0] ext_w(input logic [W_LEN-1:0] x, input logic s);
        return {{(XLEN-W_LEN){s & x[W_LEN-1]}}, x};
    endfunction

    logic [XLEN-1:0] a_ext, b_ext, q_s, r_s;
    logic            a_neg, b_neg, div_zero, ovf;

    always_comb begin
        a_ext    = w ? ext_w(src_a[W_LEN-1:0], sign) : src_a;
        b_ext    = w ? ext_w(src_b[W_LEN-1:0], sign) : src_b;
        a_neg    = sign & a_ext[XLEN-1];
        b_neg    = sign & b_ext[XLEN-1];
        mag_a    = a_neg ? -a_ext : a_ext;
        mag_b    = b_neg ? -b_ext : b_ext;
        neg_q    = a_neg ^ b_neg;
        neg_r    = a_neg;
        div_zero = (b_ext == '0);
        // operands are already extended, so -1 is all ones in both widths
        ovf      = sign & (a_ext == (w ? MIN_W : MIN_D)) & (b_ext == '1);
        special  = div_zero | ovf;
        spec_q   = div_zero ? '1 : a_ext;
        spec_r   = div_zero ? a_ext : '0;
    end

    always_comb begin
        q_s   = fix_neg_q ? -raw_q : raw_q;
        r_s   = fix_neg_r ? -raw_r : raw_r;
        res_q = fix_w ? ext_w(q_s[W_LEN-1:0], 1'b1) : q_s;
        res_r = fix_w ? ext_w(r_s[W_LEN-1:0], 1'b1) : r_s;
    end
endmodule

// File: rtl/div_unit.sv
// Iterative restoring divider: done 65 cycles after start (33 for W, 1 for special cases).
// Stalls the core via busy/done; flush aborts silently, keeping held results.
module div_unit
    import common::*;
#(
    parameter int XLEN  = 64,
    parameter int W_LEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            div_valid,
    input  logic            div_sign,
    input  logic            div_w,
    input  logic [XLEN-1:0] src_a,
    input  logic [XLEN-1:0] src_b,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] quotient,
    output logic [XLEN-1:0] remainder
);
    div_state_t      state_q, state_d;
    logic [6:0]      cnt_q;
    logic [XLEN-1:0] q_reg, r_reg, d_reg;
    logic            neg_q_q, neg_r_q, w_q;

    logic [XLEN-1:0] mag_a, mag_b, spec_q, spec_r, res_q, res_r;
    logic            neg_q, neg_r, special;
    logic [XLEN:0]   r_sh, diff;
    logic            ge;
    logic            start;

    div_operand_fix #(.XLEN(XLEN), .W_LEN(W_LEN)) u_fix (
        .src_a     (src_a),
        .src_b     (src_b),
        .sign      (div_sign),
        .w         (div_w),
        .mag_a     (mag_a),
        .mag_b     (mag_b),
        .neg_q     (neg_q),
        .neg_r     (neg_r),
        .special   (special),
        .spec_q    (spec_q),
        .spec_r    (spec_r),
        .raw_q     (q_reg),
        .raw_r     (r_reg),
        .fix_neg_q (neg_q_q),
        .fix_neg_r (neg_r_q),
        .fix_w     (w_q),
        .res_q     (res_q),
        .res_r     (res_r)
    );

    assign start = (state_q == DIV_IDLE) && div_valid && !flush;
    assign busy  = (state_q == DIV_BUSY);

    always_comb begin
        state_d = state_q;
        case (state_q)
            DIV_IDLE: if (start) state_d = special ? DIV_DONE : DIV_BUSY;
            DIV_BUSY: if (cnt_q == 7'd1) state_d = DIV_DONE;
            DIV_DONE: state_d = DIV_IDLE;
            default:  state_d = DIV_IDLE;
        endcase
        if (flush) state_d = DIV_IDLE;
    end

    always_comb begin
        r_sh = {r_reg, q_reg[XLEN-1]};
        diff = r_sh - {1'b0, d_reg};
        ge   = !diff[XLEN];
    end

    always_ff @(posedge clk) begin
        if (!reset) state_q <= DIV_IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q     <= '0;
            q_reg     <= '0;
            r_reg     <= '0;
            d_reg     <= '0;
            neg_q_q   <= 1'b0;
            neg_r_q   <= 1'b0;
            w_q       <= 1'b0;
            done      <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
        end else begin
            done <= (state_q == DIV_DONE) && !flush;
            if ((state_q == DIV_DONE) && !flush) begin
                quotient  <= res_q;
                remainder <= res_r;
            end
            if (start) begin
                // W dividends sit in the top half so 32 iterations consume exactly them
                q_reg   <= special ? spec_q : (div_w ? (mag_a << W_LEN) : mag_a);
                r_reg   <= special ? spec_r : '0;
                d_reg   <= mag_b;
                neg_q_q <= special ? 1'b0 : neg_q;
                neg_r_q <= special ? 1'b0 : neg_r;
                w_q     <= div_w;
                cnt_q   <= div_w ? 7'(DIV_ITER_W) : 7'(DIV_ITER_D);
            end else if (state_q == DIV_BUSY) begin
                q_reg <= {q_reg[XLEN-2:0], ge};
                r_reg <= ge ? diff[XLEN-1:0] : r_sh[XLEN-1:0];
                cnt_q <= cnt_q - 7'd1;
            end
        end
    end
endmodule

// File: tb/tb_div_unit.sv
// Directed vector bench for div_unit: table of operations plus reset, back-to-back and flush sequences.
module tb_div_unit;
    logic        clk = 1'b0;
    logic        reset, div_valid, div_sign, div_w, flush;
    logic [63:0] src_a, src_b;
    logic        busy, done;
    logic [63:0] quotient, remainder;

    int checks = 0;
    int errors = 0;

    div_unit dut (
        .clk       (clk),
        .reset     (reset),
        .div_valid (div_valid),
        .div_sign  (div_sign),
        .div_w     (div_w),
        .src_a     (src_a),
        .src_b     (src_b),
        .flush     (flush),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] a;
        logic [63:0] b;
        logic        sign;
        logic        w;
        logic [63:0] q;
        logic [63:0] r;
        int          lat;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%016h expected 0x%016h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called just after an edge; the following edge is cycle 0.
    task automatic run_op(input string name, input logic [63:0] a, input logic [63:0] b,
                          input logic s, input logic w, input logic [63:0] eq,
                          input logic [63:0] er, input int elat);
        int lat;
        int bcnt;
        src_a = a; src_b = b; div_sign = s; div_w = w; div_valid = 1'b1;
        tick();
        div_valid = 1'b0;
        src_a = '1; src_b = '0; div_sign = ~s; div_w = ~w;
        lat  = 0;
        bcnt = busy ? 1 : 0;
        while (!done && lat < 200) begin
            tick();
            lat++;
            bcnt += busy ? 1 : 0;
        end
        check({name, "_lat"}, 64'(lat), 64'(elat));
        check({name, "_busy"}, 64'(bcnt), 64'(elat == 1 ? 0 : elat - 1));
        check({name, "_q"}, quotient, eq);
        check({name, "_r"}, remainder, er);
        tick();
        check({name, "_pulse"}, 64'(done), 64'd0);
        check({name, "_hold_q"}, quotient, eq);
    endtask

    initial begin
        vecs[0]  = '{64'd100, 64'd7, 1'b0, 1'b0, 64'd14, 64'd2, 65};
        vecs[1]  = '{64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 1'b1, 1'b0,
                     64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFF, 65};
        vecs[2]  = '{64'd5, 64'd0, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd5, 1};
        vecs[3]  = '{64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0,
                     64'h8000_0000_0000_0000, 64'd0, 1};
        vecs[4]  = '{64'h0000_0001_8000_0000, 64'h0000_0000_FFFF_FFFF, 1'b1, 1'b1,
                     64'hFFFF_FFFF_8000_0000, 64'd0, 1};
        vecs[5]  = '{64'hFFFF_FFFF_0000_0007, 64'd2, 1'b0, 1'b1, 64'd3, 64'd1, 33};
        vecs[6]  = '{64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 1'b0,
                     64'hFFFF_FFFF_FFFF_FFFD, 64'd1, 65};
        vecs[7]  = '{64'h0000_0000_FFFF_FFFF, 64'd1, 1'b0, 1'b1,
                     64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 33};
        vecs[8]  = '{64'h1234_5678_FFFF_FFEC, 64'hABCD_0000_0000_0003, 1'b1, 1'b1,
                     64'hFFFF_FFFF_FFFF_FFFA, 64'hFFFF_FFFF_FFFF_FFFE, 33};
        vecs[9]  = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0001_0000_0000, 1'b0, 1'b0,
                     64'h0000_0000_FFFF_FFFF, 64'h0000_0000_FFFF_FFFF, 65};
        vecs[10] = '{64'h0000_0000_8000_0005, 64'hFFFF_FFFF_0000_0000, 1'b0, 1'b1,
                     64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_8000_0005, 1};

        reset = 1'b0; div_valid = 1'b0; div_sign = 1'b0; div_w = 1'b0;
        flush = 1'b0; src_a = '0; src_b = '0;
        tick();
        tick();
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_q", quotient, 64'd0);
        check("rst_r", remainder, 64'd0);
        reset = 1'b1;
        tick();

        for (int i = 0; i < 11; i++)
            run_op($sformatf("v%0d", i), vecs[i].a, vecs[i].b, vecs[i].sign, vecs[i].w,
                   vecs[i].q, vecs[i].r, vecs[i].lat);

        // reset in the middle of an iteration
        src_a = 64'd100; src_b = 64'd7; div_sign = 1'b0; div_w = 1'b0; div_valid = 1'b1;
        tick();
        div_valid = 1'b0;
        repeat (10) tick();
        check("mid_busy_pre", 64'(busy), 64'd1);
        reset = 1'b0;
        tick();
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_done", 64'(done), 64'd0);
        check("mid_rst_q", quotient, 64'd0);
        check("mid_rst_r", remainder, 64'd0);
        reset = 1'b1;
        run_op("post_rst", 64'd9, 64'd3, 1'b0, 1'b0, 64'd3, 64'd0, 65);

        // back-to-back with div_valid held high
        begin
            int lat;
            src_a = 64'd100; src_b = 64'd7; div_sign = 1'b0; div_w = 1'b0; div_valid = 1'b1;
            tick();
            lat = 0;
            while (!done && lat < 200) begin tick(); lat++; end
            check("b2b_lat1", 64'(lat), 64'd65);
            check("b2b_q1", quotient, 64'd14);
            check("b2b_r1", remainder, 64'd2);
            src_a = 64'd9; src_b = 64'd3;
            tick();
            check("b2b_start2", 64'(busy), 64'd1);
            div_valid = 1'b0;
            lat = 0;
            while (!done && lat < 200) begin tick(); lat++; end
            check("b2b_lat2", 64'(lat), 64'd65);
            check("b2b_q2", quotient, 64'd3);
            check("b2b_r2", remainder, 64'd0);
            tick();
        end

        // flush mid-operation: no done pulse, results retained (3, 0)
        begin
            int seen;
            src_a = 64'd100; src_b = 64'd7; div_valid = 1'b1;
            tick();
            div_valid = 1'b0;
            repeat (5) tick();
            flush = 1'b1;
            tick();
            flush = 1'b0;
            check("flush_busy", 64'(busy), 64'd0);
            seen = 0;
            repeat (80) begin tick(); seen += done ? 1 : 0; end
            check("flush_nodone", 64'(seen), 64'd0);
            check("flush_hold_q", quotient, 64'd3);
            check("flush_hold_r", remainder, 64'd0);

            // flush beats a new request in IDLE
            div_valid = 1'b1; flush = 1'b1;
            tick();
            check("flush_prio", 64'(busy), 64'd0);
            div_valid = 1'b0; flush = 1'b0;
            tick();
            check("flush_prio_done", 64'(done), 64'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Iterative multi-cycle integer divider for the RV64 core. It services DIV, DIVU, REM, REMU, DIVW, DIVUW, REMW and REMUW.
- It is the responder to the decoder's divide request signals: div_valid, div_sign and div_w.
- It returns quotient and remainder together. Writeback selects the quotient or the remainder by the existing m2reg codes.
- The core stalls PC and register writes while div_valid=1 and done=0.

Parameters:
XLEN, 64, operand and result width
W_LEN, 32, width used for the *W variants

Ports:
clk  in  1  clock; all state updates on the rising edge
reset  in  1  synchronous, active-low; 0 = reset
div_valid  in  1  request from the decoder; level-held until done is seen
div_sign  in  1  1 = signed (DIV/REM[W]), 0 = unsigned
div_w  in  1  1 = 32-bit W variant
src_a  in  XLEN  dividend (rs1)
src_b  in  XLEN  divisor (rs2)
flush  in  1  abort any in-flight operation
busy  out  1  1 while in BUSY
done  out  1  one-cycle pulse; results valid in this cycle
quotient  out  XLEN  quotient result
remainder  out  XLEN  remainder result

Behaviour:
- Reset: reset=0 at an edge forces IDLE and clears busy, done, quotient and remainder to 0. This holds in any state, including mid-iteration.
- States: IDLE, BUSY, DONE.
- IDLE:
  - If div_valid=1 and flush=0, latch the operands and div_sign/div_w.
  - Divide-by-zero or signed overflow goes straight to DONE.
  - Otherwise go to BUSY with the iteration counter set to N (N=64, or 32 when div_w=1).
- BUSY:
  - Restoring division, one quotient bit per cycle.
  - The counter decrements each cycle; when it reaches 0, go to DONE.
- DONE:
  - done=1 for exactly one cycle; quotient and remainder are stable.
  - The next state is IDLE unconditionally.
- Latency (start edge = cycle 0):
  - Normal case: done at cycle N+1, i.e. 65 (64-bit) or 33 (W).
  - Special cases: done at cycle 1.
- Result holding: quotient and remainder keep their value after DONE until the next operation reaches DONE.
- Back-to-back: if div_valid is still 1 in the cycle after DONE, it is a new instruction and starts a new operation. There is no re-trigger inside DONE itself.
- Operand width:
  - When div_w=1, use only src_a[31:0] and src_b[31:0].
  - For signed W operations, sign-extend the operands from bit 31; for unsigned W operations, zero-extend.
- Signed operations:
  - Divide magnitudes unsigned.
  - Negate the quotient iff the operand signs differ.
  - The remainder takes the sign of the dividend.
- Divide by zero (divisor=0 after width masking): quotient = all ones, remainder = dividend.
- Signed overflow (dividend = most negative value, divisor = -1): quotient = dividend, remainder = 0.
- W results: the 32-bit quotient and remainder are sign-extended from bit 31 to XLEN. This applies to DIVUW/REMUW too, per RV64.
- Operand changes: changes on src_a/src_b/div_sign/div_w during BUSY are ignored.
- flush=1: any state goes to IDLE at the next edge, with busy=0 and no done pulse. Held results are unchanged. flush takes priority over starting a new operation in IDLE.
- div_valid dropping to 0 during BUSY does not abort the operation; it runs to DONE.

Decomposition:
- Shared package common:
  - typedef u64 (XLEN word)
  - enum div_state_t {DIV_IDLE, DIV_BUSY, DIV_DONE}
  - localparams DIV_ITER_D=64 and DIV_ITER_W=32
- One combinational sub-module, div_operand_fix, which does:
  - W masking and extension
  - magnitude conversion
  - divide-by-zero and overflow detection
  - final sign correction and W sign-extension
- div_unit holds the FSM, counter and shift registers.

Test Plan:
1. DIVU, a=100, b=7, div_w=0 -> busy for 64 cycles; done at cycle 65 with quotient=14, remainder=2; done is high exactly one cycle.
2. DIV, a=-7 (0xFFFF_FFFF_FFFF_FFF9), b=2 -> quotient=0xFFFF_FFFF_FFFF_FFFD, remainder=0xFFFF_FFFF_FFFF_FFFF.
3. DIVU, a=5, b=0 -> done at cycle 1 with quotient=0xFFFF_FFFF_FFFF_FFFF, remainder=5. DIV, a=0x8000_0000_0000_0000, b=-1 -> quotient=0x8000_0000_0000_0000, remainder=0.
4. DIVW, a=0x0000_0001_8000_0000, b=0xFFFF_FFFF -> overflow path; quotient=0xFFFF_FFFF_8000_0000, remainder=0. REMUW, a=0xFFFF_FFFF_0000_0007, b=2 -> 32 iterations; done at cycle 33; remainder=1, quotient=3.
5. Pull reset low at BUSY cycle 10 -> next edge: busy=0, done=0, quotient=remainder=0. With reset released and div_valid=1, a new operation starts and completes correctly.
6. div_valid held high across two consecutive DIVU ops (100/7, then 9/3) -> first done at cycle 65, second starts at cycle 66 and gives done with quotient=3, remainder=0. flush during BUSY -> IDLE next edge, no done pulse, previous results retained.
